// File: rtl/branch_cache_ctrl.sv
// Fetch-stage branch target cache: same-cycle PC lookup, learns resolved
// branch/j/jal targets from EX, free-slot-then-round-robin replacement, swept flush.
module branch_cache_ctrl #(
  parameter int ENTRIES = 8,
  parameter int ADDR_W  = 32,
  parameter int PTR_W   = 3
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [ADDR_W-1:0] PC,
  output logic [ADDR_W-1:0] oCacheAddress,
  output logic              ocCache,
  input  logic              UpdValid,
  output logic              UpdReady,
  input  logic [ADDR_W-1:0] UpdPC,
  input  logic [ADDR_W-1:0] UpdTarget,
  input  logic              UpdIsJr,
  input  logic              Flush,
  output logic              Busy,
  output logic [PTR_W:0]    Count
);

  typedef enum logic {IDLE, FLUSH} state_t;

  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(ENTRIES - 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);

  state_t              state;
  logic [ENTRIES-1:0]  valid;
  logic [ADDR_W-1:0]   tag    [ENTRIES];
  logic [ADDR_W-1:0]   target [ENTRIES];
  logic [PTR_W-1:0]    ptr;
  logic [PTR_W-1:0]    idx;

  logic                lookHit;
  logic [ADDR_W-1:0]   lookAddr;
  logic                updHit;
  logic [PTR_W-1:0]    updIdx;
  logic                freeFound;
  logic [PTR_W-1:0]    freeIdx;
  logic                wrEn;
  logic [PTR_W-1:0]    wrIdx;

  // Descending scans so the lowest matching / free index wins.
  always_comb begin
    lookHit   = 1'b0;
    lookAddr  = '0;
    updHit    = 1'b0;
    updIdx    = '0;
    freeFound = 1'b0;
    freeIdx   = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (valid[i] && tag[i] == PC) begin
        lookHit  = 1'b1;
        lookAddr = target[i];
      end
      if (valid[i] && tag[i] == UpdPC) begin
        updHit = 1'b1;
        updIdx = PTR_W'(i);
      end
      if (!valid[i]) begin
        freeFound = 1'b1;
        freeIdx   = PTR_W'(i);
      end
    end
  end

  assign ocCache       = Rst && (state == IDLE) && lookHit;
  assign oCacheAddress = ocCache ? lookAddr : '0;
  assign UpdReady      = Rst && (state == IDLE) && !Flush;
  assign Busy          = Rst && (state == FLUSH);

  // jr reports are consumed without touching the table.
  assign wrEn  = UpdValid && UpdReady && !UpdIsJr;
  assign wrIdx = updHit ? updIdx : (freeFound ? freeIdx : ptr);

  always_ff @(posedge Clk) begin
    if (wrEn) begin
      tag[wrIdx]    <= UpdPC;
      target[wrIdx] <= UpdTarget;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state <= IDLE;
      valid <= '0;
      ptr   <= '0;
      idx   <= '0;
      Count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Flush) begin
            state <= FLUSH;
            idx   <= '0;
          end else if (wrEn && !updHit) begin
            valid[wrIdx] <= 1'b1;
            if (freeFound) Count <= Count + CNT_ONE;
            else           ptr   <= ptr + PTR_ONE;
          end
        end
        FLUSH: begin
          valid[idx] <= 1'b0;
          if (valid[idx]) Count <= Count - CNT_ONE;
          idx <= idx + PTR_ONE;
          if (idx == LAST_IDX) begin
            state <= IDLE;
            ptr   <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_cache_ctrl.sv
// Bench for branch_cache_ctrl: directed vector table, flush/reset sequences,
// then random traffic against a table-level reference model.
module tb_branch_cache_ctrl;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic [31:0] PC = '0;
  logic [31:0] oCacheAddress;
  logic        ocCache;
  logic        UpdValid = 1'b0;
  logic        UpdReady;
  logic [31:0] UpdPC = '0;
  logic [31:0] UpdTarget = '0;
  logic        UpdIsJr = 1'b0;
  logic        Flush = 1'b0;
  logic        Busy;
  logic [3:0]  Count;

  always #5 Clk = ~Clk;

  branch_cache_ctrl #(.ENTRIES(8), .ADDR_W(32), .PTR_W(3)) dut (
    .Clk(Clk), .Rst(Rst), .PC(PC), .oCacheAddress(oCacheAddress), .ocCache(ocCache),
    .UpdValid(UpdValid), .UpdReady(UpdReady), .UpdPC(UpdPC), .UpdTarget(UpdTarget),
    .UpdIsJr(UpdIsJr), .Flush(Flush), .Busy(Busy), .Count(Count)
  );

  int nCmp = 0;
  int nFail = 0;

  // Reference model: the table as plain arrays plus a sweep position.
  bit          mValid [8];
  logic [31:0] mTag [8];
  logic [31:0] mTgt [8];
  int          mPtr = 0;
  bit          mFlushing = 0;
  int          mSweep = 0;

  logic lastBusy, lastReady;
  logic [3:0] lastCount;
  logic lastHit;

  typedef struct {
    logic        rst;
    logic [31:0] pc;
    logic        uv;
    logic [31:0] upc;
    logic [31:0] utgt;
    logic        ujr;
    logic        fl;
    logic        eHit;
    logic [31:0] eAddr;
    int          eCount;
    logic        eReady;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(logic r, logic [31:0] pc, logic uv, logic [31:0] upc,
                              logic [31:0] utgt, logic ujr, logic fl, logic eh,
                              logic [31:0] ea, int ec, logic er);
    vec_t v;
    v.rst = r; v.pc = pc; v.uv = uv; v.upc = upc; v.utgt = utgt; v.ujr = ujr; v.fl = fl;
    v.eHit = eh; v.eAddr = ea; v.eCount = ec; v.eReady = er;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int modelCount();
    int c = 0;
    for (int i = 0; i < 8; i++) if (mValid[i]) c++;
    return c;
  endfunction

  task automatic drive(input logic r, input logic [31:0] pc, input logic uv,
                       input logic [31:0] upc, input logic [31:0] utgt,
                       input logic ujr, input logic fl);
    Rst = r; PC = pc; UpdValid = uv; UpdPC = upc; UpdTarget = utgt; UpdIsJr = ujr; Flush = fl;
  endtask

  task automatic sampleOuts();
    lastBusy = Busy; lastReady = UpdReady; lastCount = Count; lastHit = ocCache;
  endtask

  task automatic checkModel();
    bit eh = 0;
    logic [31:0] ea = '0;
    if (Rst && !mFlushing)
      for (int i = 7; i >= 0; i--)
        if (mValid[i] && mTag[i] == PC) begin eh = 1; ea = mTgt[i]; end
    chk("hit", ocCache, eh);
    chk("addr", oCacheAddress, ea);
    chk("count", Count, modelCount());
    chk("ready", UpdReady, Rst && !mFlushing && !Flush);
    chk("busy", Busy, Rst && mFlushing);
  endtask

  // Applies the rules for one rising edge using the inputs held across it.
  task automatic edgeModel();
    int slot = -1;
    if (!Rst) begin
      for (int i = 0; i < 8; i++) mValid[i] = 0;
      mPtr = 0; mFlushing = 0;
    end else if (mFlushing) begin
      mValid[mSweep] = 0;
      if (mSweep == 7) begin mFlushing = 0; mPtr = 0; end
      mSweep++;
    end else if (Flush) begin
      mFlushing = 1; mSweep = 0;
    end else if (UpdValid && !UpdIsJr) begin
      for (int i = 7; i >= 0; i--) if (mValid[i] && mTag[i] == UpdPC) slot = i;
      if (slot < 0) for (int i = 7; i >= 0; i--) if (!mValid[i]) slot = i;
      if (slot < 0) begin slot = mPtr; mPtr = (mPtr + 1) % 8; end
      mValid[slot] = 1; mTag[slot] = UpdPC; mTgt[slot] = UpdTarget;
    end
  endtask

  task automatic cyc(input logic r, input logic [31:0] pc, input logic uv,
                     input logic [31:0] upc, input logic [31:0] utgt,
                     input logic ujr, input logic fl);
    @(negedge Clk);
    drive(r, pc, uv, upc, utgt, ujr, fl);
    #1;
    checkModel();
    sampleOuts();
    @(posedge Clk);
    edgeModel();
  endtask

  initial begin
    int busyCycles;
    logic        hold;
    logic [31:0] hPC, hTgt;
    logic        hJr;
    logic        r, uv, ujr, fl;
    logic [31:0] pc, upc, utgt;

    // Basic lookup, learn, in-place update, jr (rows 0-7)
    tv.push_back(mk(0, 'h14, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(1, 'h14, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    tv.push_back(mk(1, 'h14, 1, 'h14, 'h10, 0, 0, 0, 0, 0, 1));
    tv.push_back(mk(1, 'h14, 0, 0, 0, 0, 0, 1, 'h10, 1, 1));
    tv.push_back(mk(1, 'h14, 1, 'h14, 'h40, 0, 0, 1, 'h10, 1, 1));
    tv.push_back(mk(1, 'h14, 0, 0, 0, 0, 0, 1, 'h40, 1, 1));
    tv.push_back(mk(1, 'h30, 1, 'h30, 'h80, 1, 0, 0, 0, 1, 1));
    tv.push_back(mk(1, 'h30, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    // Reset, fill, then round-robin replacement (rows 8-22)
    tv.push_back(mk(0, 'h14, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    for (int k = 0; k < 8; k++)
      tv.push_back(mk(1, 'h100, 1, 'h100 + 4 * k, 'h1000 + k, 0, 0,
                      k >= 1, (k >= 1) ? 32'h1000 : 32'h0, k, 1));
    tv.push_back(mk(1, 'h100, 1, 'h200, 'h2000, 0, 0, 1, 'h1000, 8, 1));
    tv.push_back(mk(1, 'h100, 0, 0, 0, 0, 0, 0, 0, 8, 1));
    tv.push_back(mk(1, 'h200, 1, 'h300, 'h3000, 0, 0, 1, 'h2000, 8, 1));
    tv.push_back(mk(1, 'h104, 0, 0, 0, 0, 0, 0, 0, 8, 1));
    tv.push_back(mk(1, 'h300, 0, 0, 0, 0, 0, 1, 'h3000, 8, 1));
    tv.push_back(mk(1, 'h108, 0, 0, 0, 0, 0, 1, 'h1002, 8, 1));

    @(negedge Clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    @(posedge Clk);
    edgeModel();

    foreach (tv[i]) begin
      @(negedge Clk);
      drive(tv[i].rst, tv[i].pc, tv[i].uv, tv[i].upc, tv[i].utgt, tv[i].ujr, tv[i].fl);
      #1;
      chk($sformatf("row%0d.hit", i), ocCache, tv[i].eHit);
      chk($sformatf("row%0d.addr", i), oCacheAddress, tv[i].eAddr);
      chk($sformatf("row%0d.count", i), Count, tv[i].eCount);
      chk($sformatf("row%0d.ready", i), UpdReady, tv[i].eReady);
      @(posedge Clk);
      edgeModel();
    end

    // Flush on a full table while an update is pending
    cyc(1, 'h200, 1, 'h400, 'h4000, 0, 1);
    chk("flushReqReady", lastReady, 0);
    busyCycles = 0;
    for (int k = 0; k < 20; k++) begin
      cyc(1, 'h200, 1, 'h400, 'h4000, 0, 0);
      if (lastBusy) begin
        busyCycles++;
        chk("sweepHit", lastHit, 0);
      end else break;
    end
    chk("busyLen", busyCycles, 8);
    chk("postSweepCount", lastCount, 0);
    chk("postSweepReady", lastReady, 1);
    cyc(1, 'h400, 0, 0, 0, 0, 0);
    chk("heldUpdLanded", lastHit, 1);
    chk("heldUpdCount", lastCount, 1);

    // Reset during the third sweep cycle
    cyc(1, 'h400, 1, 'h500, 'h5000, 0, 0);
    cyc(1, 'h400, 0, 0, 0, 0, 1);
    cyc(1, 'h400, 0, 0, 0, 0, 1);
    cyc(1, 'h400, 0, 0, 0, 0, 0);
    cyc(0, 'h400, 0, 0, 0, 0, 0);
    cyc(1, 'h400, 0, 0, 0, 0, 0);
    chk("rstAbortBusy", lastBusy, 0);
    chk("rstAbortCount", lastCount, 0);
    chk("rstAbortHit", lastHit, 0);

    // Random traffic over a small PC pool so hits and replacements recur
    hold = 0; hPC = '0; hTgt = '0; hJr = 0;
    for (int n = 0; n < 600; n++) begin
      r  = ($urandom_range(63) != 0);
      fl = ($urandom_range(19) == 0);
      pc = 32'h40 + 4 * $urandom_range(15);
      if (hold) begin
        uv = 1; upc = hPC; utgt = hTgt; ujr = hJr;
      end else begin
        uv   = $urandom_range(1);
        upc  = 32'h40 + 4 * $urandom_range(15);
        utgt = $urandom;
        ujr  = ($urandom_range(7) == 0);
      end
      cyc(r, pc, uv, upc, utgt, ujr, fl);
      hold = uv && !lastReady;
      hPC = upc; hTgt = utgt; hJr = ujr;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
